// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared types and constants for the centisecond stopwatch
// Rev 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  localparam int BCD_W            = 4;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int DIGIT_MAX_DEF    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// ============================================================================
// stopwatch_counter_if : control inputs and display outputs of the stopwatch
// Rev 1.0 - initial release
// ============================================================================
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic                 tick_in;
  logic                 start_stop;
  logic                 clear;
  logic [4*BCD_W-1:0]   digits;
  logic                 running;
  logic                 wrap;

  modport master (
    output tick_in, start_stop, clear,
    input  digits, running, wrap
  );

  modport slave (
    input  tick_in, start_stop, clear,
    output digits, running, wrap
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// bcd_digit : one BCD counter digit that wraps at MAX and carries out
// Rev 1.0 - initial release
// ============================================================================
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  wire logic             I_CLK,
  input  wire logic             Rst,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic [BCD_W-1:0]      q,
  output logic                  carry_out
);

  localparam logic [BCD_W-1:0] C_MAX = BCD_W'(MAX);

  // >= rather than == so a corrupted digit still returns to a legal value
  always_ff @(posedge I_CLK) begin
    if (Rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q >= C_MAX) ? '0 : q + 1'b1;
    end
  end

  assign carry_out = inc & (q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// stopwatch_counter : SS.cc BCD stopwatch advanced by rising edges of tick_in
// Rev 1.0 - initial release
// ============================================================================
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int DIGIT_MAX    = DIGIT_MAX_DEF
) (
  input  wire logic          I_CLK,
  input  wire logic          Rst,
  stopwatch_counter_if.slave sw
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_running;
  logic                 r_wrap;
  logic                 r_tick_d;
  logic                 w_tick_rise;
  logic                 w_count;
  logic [4:0]           w_carry;
  logic [4*BCD_W-1:0]   w_digits;

  assign w_tick_rise = sw.tick_in & ~r_tick_d;
  // Counting uses the pre-edge state, so a tick with start_stop in RUN still counts
  assign w_count     = w_tick_rise & (r_state == RUN) & ~sw.clear;
  assign w_carry[0]  = w_count;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    localparam int C_DMAX = (i == 3) ? SEC_TENS_MAX : DIGIT_MAX;
    bcd_digit #(
      .MAX       (C_DMAX)
    ) u_digit (
      .I_CLK     (I_CLK),
      .Rst       (Rst),
      .clr       (sw.clear),
      .inc       (w_carry[i]),
      .q         (w_digits[i*BCD_W +: BCD_W]),
      .carry_out (w_carry[i+1])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (sw.start_stop) w_state_nxt = RUN;
      RUN:     if (sw.start_stop) w_state_nxt = PAUSE;
      PAUSE:   if (sw.start_stop) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (sw.clear) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
      r_tick_d  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_wrap    <= w_carry[4];
      r_tick_d  <= sw.tick_in;
    end
  end

  assign sw.digits  = w_digits;
  assign sw.running = r_running;
  assign sw.wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_counter : randomized and directed checks against a time model
// Rev 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Reference model: elapsed centiseconds plus a run mode (0 idle, 1 run, 2 pause)
  int   m_cnt;
  int   m_mode;
  bit   m_wrap;
  bit   m_prev;

  stopwatch_counter_if sw ();

  stopwatch_counter u_dut (
    .I_CLK (clk),
    .Rst   (rst),
    .sw    (sw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] to_bcd(input int c);
    to_bcd = {4'(c / 1000), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  task automatic model_update(input bit t, input bit ss, input bit cl, input bit r);
    bit rise;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_wrap = 0; m_prev = 0;
    end else begin
      rise   = t && !m_prev;
      m_prev = t;
      m_wrap = 0;
      if (cl) begin
        m_mode = 0; m_cnt = 0;
      end else begin
        if (rise && m_mode == 1) begin
          if (m_cnt == 5999) begin m_cnt = 0; m_wrap = 1; end
          else m_cnt++;
        end
        if (ss) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
  endtask

  task automatic step(input bit t, input bit ss, input bit cl, input bit r);
    sw.tick_in = t; sw.start_stop = ss; sw.clear = cl; rst = r;
    @(posedge clk);
    model_update(t, ss, cl, r);
    @(negedge clk);
  endtask

  task automatic div_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic fast_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b0 || sw.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: digits=%h running=%b wrap=%b, want 0000/0/0", sw.digits, sw.running, sw.wrap);
    end
    for (int i = 0; i < 60; i++) begin
      step(i % 20 >= 10, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_start: cycle %0d digits=%h running=%b, want 0000/0", i, sw.digits, sw.running);
      end
    end
  endtask

  task automatic test_basic_count;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12 * 20; i++) begin
      step(i % 20 >= 10, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (sw.digits !== to_bcd(m_cnt) || sw.running !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_count: cycle %0d digits=%h running=%b, want %h/1", i, sw.digits, sw.running, to_bcd(m_cnt));
      end
    end
    n_tests++;
    if (sw.digits !== 16'h0012) begin
      n_fail++;
      $display("FAIL basic_final: digits=%h, want 0012", sw.digits);
    end
  endtask

  task automatic test_pause_resume;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    div_ticks(5);
    n_tests++;
    if (sw.digits !== 16'h0012 || sw.running !== 1'b0) begin
      n_fail++;
      $display("FAIL paused_hold: digits=%h running=%b, want 0012/0", sw.digits, sw.running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    div_ticks(3);
    n_tests++;
    if (sw.digits !== 16'h0015 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL resumed: digits=%h running=%b, want 0015/1", sw.digits, sw.running);
    end
  endtask

  task automatic test_carry_wrap;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    fast_ticks(599);
    n_tests++;
    if (sw.digits !== 16'h0599) begin
      n_fail++;
      $display("FAIL preload_599: digits=%h, want 0599", sw.digits);
    end
    fast_ticks(1);
    n_tests++;
    if (sw.digits !== 16'h0600) begin
      n_fail++;
      $display("FAIL carry_600: digits=%h, want 0600", sw.digits);
    end
    for (int i = 0; i < 5399; i++) begin
      fast_ticks(1);
      n_tests++;
      if (sw.digits !== to_bcd(m_cnt) || sw.wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL run_to_max: tick %0d digits=%h wrap=%b, want %h/0", i, sw.digits, sw.wrap, to_bcd(m_cnt));
      end
    end
    n_tests++;
    if (sw.digits !== 16'h5999) begin
      n_fail++;
      $display("FAIL at_5999: digits=%h, want 5999", sw.digits);
    end
    fast_ticks(1);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.wrap !== 1'b1 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_event: digits=%h wrap=%b running=%b, want 0000/1/1", sw.digits, sw.wrap, sw.running);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sw.wrap !== 1'b0 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: wrap=%b running=%b, want 0/1", sw.wrap, sw.running);
    end
  endtask

  task automatic test_simultaneous;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_and_start: digits=%h running=%b, want 0000/0", sw.digits, sw.running);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_start_idle: digits=%h running=%b, want 0000/1", sw.digits, sw.running);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (sw.digits !== 16'h0001 || sw.running !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_stop_run: digits=%h running=%b, want 0001/0", sw.digits, sw.running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b0 || sw.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_with_clear: digits=%h running=%b wrap=%b, want 0000/0/0", sw.digits, sw.running, sw.wrap);
    end
  endtask

  task automatic test_reset_mid_run;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    fast_ticks(37);
    n_tests++;
    if (sw.digits !== 16'h0037 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: digits=%h running=%b, want 0037/1", sw.digits, sw.running);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b0 || sw.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: digits=%h running=%b wrap=%b, want 0000/0/0", sw.digits, sw.running, sw.wrap);
    end
    fast_ticks(5);
    n_tests++;
    if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: digits=%h running=%b, want 0000/0", sw.digits, sw.running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    fast_ticks(1);
    n_tests++;
    if (sw.digits !== 16'h0001 || sw.running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: digits=%h running=%b, want 0001/1", sw.digits, sw.running);
    end
  endtask

  task automatic test_random;
    bit t, ss, cl, r;
    t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) t = ~t;
      ss = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 199) == 0);
      r  = ($urandom_range(0, 499) == 0);
      step(t, ss, cl, r);
      n_tests++;
      if (sw.digits !== to_bcd(m_cnt) || sw.running !== (m_mode == 1) || sw.wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL random: cycle %0d digits=%h running=%b wrap=%b, want %h/%b/%b",
                 i, sw.digits, sw.running, sw.wrap, to_bcd(m_cnt), (m_mode == 1), m_wrap);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_cnt = 0; m_mode = 0; m_wrap = 0; m_prev = 0;
    rst = 1'b1;
    sw.tick_in = 1'b0; sw.start_stop = 1'b0; sw.clear = 1'b0;
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_carry_wrap();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
